// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline constants: opcode/func encodings, MD latencies and field slices.
package stall_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;

    localparam logic [3:0] MD_LOAD_MULT = 4'd5;
    localparam logic [3:0] MD_LOAD_DIV  = 4'd10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [5:0] func_of(input logic [31:0] ir);
        return ir[5:0];
    endfunction

endpackage

// File: rtl/stall_ctrl_md_counter.sv
// Multiply/divide busy counter: IDLE/BUSY FSM owning md_cnt and a registered md_busy.
module md_counter
    import stall_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_div,
    output logic [3:0] md_cnt,
    output logic       md_busy
);

    md_state_e state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else if (start) begin
            // A start always reloads, even mid-count: the most recent op owns HI/LO.
            state   <= MD_BUSY;
            md_cnt  <= is_div ? MD_LOAD_DIV : MD_LOAD_MULT;
            md_busy <= 1'b1;
        end else begin
            case (state)
                MD_BUSY: begin
                    if (md_cnt != '0) md_cnt <= md_cnt - 4'd1;
                    if (md_cnt <= 4'd1) begin
                        state   <= MD_IDLE;
                        md_busy <= 1'b0;
                    end
                end
                default: begin
                    md_cnt  <= '0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard unit: Tuse/Tnew data-stall decode plus structural stall on the multiply/divide unit.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic        RWE_E,
    input  logic        RWE_M,
    output logic        stall,
    output logic        md_busy,
    output logic [3:0]  md_cnt
);

    logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
    logic       md_start, md_div, md_class_d;
    logic       hz_e, hz_m, data_stall, md_stall;
    logic [5:0] op_d, fn_d, op_e, fn_e;

    assign op_d = op_of(IR_D);
    assign fn_d = func_of(IR_D);
    assign op_e = op_of(IR_E);
    assign fn_e = func_of(IR_E);

    always_comb begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
        if (op_d == OP_BEQ || op_d == OP_BNE) begin
            tuse_rs = 2'd0;
            tuse_rt = 2'd0;
        end else if (op_d == OP_SW) begin
            tuse_rt = 2'd2;
        end else if (op_d == OP_SPECIAL && fn_d == FN_JR) begin
            tuse_rs = 2'd0;
        end
    end

    // ALU class: R-type other than jr and the MD ops that write only HI/LO, plus I-type 001xxx.
    always_comb begin
        tnew_e = 2'd0;
        if (op_e == OP_LW) begin
            tnew_e = 2'd2;
        end else if (IR_E != '0 && op_e == OP_SPECIAL) begin
            if (!(fn_e inside {FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO}))
                tnew_e = 2'd1;
        end else if (op_e[5:3] == 3'b001) begin
            tnew_e = 2'd1;
        end
    end

    assign tnew_m = (op_of(IR_M) == OP_LW) ? 2'd1 : 2'd0;

    assign hz_e = RWE_E && A3_E != '0 &&
                  ((rs_of(IR_D) == A3_E && tuse_rs < tnew_e) ||
                   (rt_of(IR_D) == A3_E && tuse_rt < tnew_e));
    assign hz_m = RWE_M && A3_M != '0 &&
                  ((rs_of(IR_D) == A3_M && tuse_rs < tnew_m) ||
                   (rt_of(IR_D) == A3_M && tuse_rt < tnew_m));
    assign data_stall = hz_e || hz_m;

    assign md_start   = op_e == OP_SPECIAL && fn_e inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    assign md_div     = fn_e == FN_DIV || fn_e == FN_DIVU;
    assign md_class_d = op_d == OP_SPECIAL &&
                        fn_d inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                                     FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO};
    assign md_stall   = (md_busy || md_start) && md_class_d;

    assign stall = data_stall || md_stall;

    md_counter u_md_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .is_div  (md_div),
        .md_cnt  (md_cnt),
        .md_busy (md_busy)
    );

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock; one clock domain only.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-003 SHALL have port IR_D / IR_E / IR_M, input, 32 each, instruction words in the D, E and M stages; 0 means bubble.
REQ-004 SHALL have port A3_E / A3_M, input, 5 each, destination register in E and M.
REQ-005 SHALL have port RWE_E / RWE_M, input, 1 each, register-write enable in E and M.
REQ-006 SHALL have port stall, output, 1: hold PC and the D register, and inject a bubble into E.
REQ-007 SHALL have port md_busy, output, 1: the multiply/divide unit is computing.
REQ-008 SHALL have port md_cnt, output, 4: remaining busy cycles.

Function
REQ-009 Tuse for rs SHALL be 0 for beq, bne and jr, and 1 otherwise; Tuse for rt SHALL be 0 for beq and bne, 2 for sw, and 1 otherwise.
REQ-010 Tnew SHALL be derived from IR_E: lw=2, ALU/mfhi/mflo=1, others 0. It SHALL be derived from IR_M: lw=1, others 0.
REQ-011 Data stall SHALL be 1 when, for stage X in {E,M}, RWE_X=1, A3_X!=0, the IR_D rs or rt field equals A3_X, and Tuse < Tnew_X for that operand.
REQ-012 md start SHALL be 1 when IR_E is mult, multu, div or divu (opcode 000000; func 011000, 011001, 011010 or 011011).
REQ-013 On a clock edge with md start=1, md_cnt SHALL load 5 for mult/multu or 10 for div/divu.
REQ-014 While md_cnt != 0 and md start=0, md_cnt SHALL decrement by 1 per cycle, saturating at 0 with no wrap.
REQ-015 md_busy SHALL equal (md_cnt != 0), registered-state derived with no combinational input path.
REQ-016 MD stall SHALL be 1 when (md_busy or md start) and IR_D is an MD-class instruction: mult, multu, div, divu, mfhi, mflo, mthi or mtlo.
REQ-017 stall SHALL equal (data stall or MD stall) and SHALL be combinational in the same cycle.
REQ-018 md start while md_busy=1 SHALL reload the counter, so the last start wins; REQ-016 prevents this in normal flow.
REQ-019 A bubble (IR=0) SHALL produce Tnew=0, SHALL NOT be an MD start, and SHALL NOT be MD-class.
REQ-020 Stall latency SHALL be 0 cycles; the stall clears in the first cycle its condition is false.
REQ-021 The FSM SHALL have states IDLE (md_cnt=0) and BUSY (md_cnt!=0).
REQ-022 FSM transitions SHALL be: IDLE->BUSY on md start; BUSY->IDLE when md_cnt=1 and no start; BUSY->BUSY otherwise.

Reset
REQ-023 Reset low SHALL asynchronously force md_cnt=0, md_busy=0 and the FSM to IDLE.
REQ-024 stall SHALL follow REQ-017 with state cleared while reset is low.
REQ-025 Reset mid-operation SHALL abandon the MD count; there SHALL be no pending stall after release.

Structure
REQ-026 Opcode/func constants (SPECIAL, lw, sw, beq, bne, jr and the MD funcs) and the load values 5 and 10 SHALL live in the shared pipeline constants package.
REQ-027 Field slices Op, Rs, Rt and Func SHALL come from that package.
REQ-028 One sub-module, md_counter, SHALL own md_cnt and the FSM; Tuse/Tnew decode SHALL stay in stall_ctrl.

Verification
REQ-029 SHALL check: IR_E=lw $8; IR_D=add $9,$8,$1 -> stall=1 for 1 cycle; next cycle IR_M=lw $8 -> stall=0.
REQ-030 SHALL check: IR_E=addu $8; IR_D=beq $8,$0 -> stall=1. Then IR_M=addu $8 -> stall=0.
REQ-031 SHALL check: IR_E=lw $8; IR_D=sw $8,0($2) -> stall=0, since rt Tuse=2.
REQ-032 SHALL check: IR_E=div, then IR_D=mflo -> stall=1 for 11 cycles (start cycle plus md_cnt 10..1); md_busy falls when md_cnt reaches 0.
REQ-033 SHALL check: IR_E=mult with IR_D=addu $3 -> stall=0, md_cnt=5 next cycle, counts 5,4,3,2,1,0.
REQ-034 SHALL check: reset pulsed low at md_cnt=7 -> md_cnt=0 and md_busy=0 immediately; IR_D=mfhi after release -> stall=0; A3_E=0 with RWE_E=1 -> never stalls.
